// File: rtl/async_fifo_core.sv
// async_fifo_core: show-ahead single-clock FIFO with full/empty and almost-full/almost-empty flags.
module async_fifo_core #(
   parameter int DSIZE = 8,
   parameter int ASIZE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             winc,
   input  logic [DSIZE-1:0] wdata,
   output logic             wfull,
   output logic             awfull,
   input  logic             rinc,
   output logic [DSIZE-1:0] rdata,
   output logic             rempty,
   output logic             arempty
);
   localparam int DEPTH = 1 << ASIZE;
   localparam logic [ASIZE:0] L_FULL  = {1'b1, {ASIZE{1'b0}}};
   localparam logic [ASIZE:0] L_AFULL = {1'b0, {ASIZE{1'b1}}};
   localparam logic [ASIZE:0] L_ONE   = {{ASIZE{1'b0}}, 1'b1};
   logic [DSIZE-1:0] r_mem [DEPTH];
   logic [ASIZE:0]   r_wptr, r_rptr;
   logic             r_wfull, r_awfull, r_rempty, r_arempty;
   logic             w_wr, w_rd;
   logic [ASIZE:0]   w_wptr_nxt, w_rptr_nxt, w_cnt_nxt;
   assign w_wr       = winc & ~r_wfull;
   assign w_rd       = rinc & ~r_rempty;
   assign w_wptr_nxt = r_wptr + {{ASIZE{1'b0}}, w_wr};
   assign w_rptr_nxt = r_rptr + {{ASIZE{1'b0}}, w_rd};
   assign w_cnt_nxt  = w_wptr_nxt - w_rptr_nxt;
   // Flags are registered from next-state pointers: same timing as a decode, but glitch-free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_wfull   <= 1'b0;
         r_awfull  <= 1'b0;
         r_rempty  <= 1'b1;
         r_arempty <= 1'b1;
      end else begin
         r_wptr    <= w_wptr_nxt;
         r_rptr    <= w_rptr_nxt;
         r_wfull   <= w_cnt_nxt == L_FULL;
         r_awfull  <= w_cnt_nxt >= L_AFULL;
         r_rempty  <= w_cnt_nxt == '0;
         r_arempty <= w_cnt_nxt <= L_ONE;
      end
   end
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr[ASIZE-1:0]] <= wdata;
   end
   assign rdata   = r_mem[r_rptr[ASIZE-1:0]];
   assign wfull   = r_wfull;
   assign awfull  = r_awfull;
   assign rempty  = r_rempty;
   assign arempty = r_arempty;
endmodule

// File: tb/tb_async_fifo_core.sv
// tb_async_fifo_core: directed scenario tests for the show-ahead FIFO.
module tb_async_fifo_core;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       winc = 1'b0, rinc = 1'b0;
   logic [7:0] wdata = '0;
   logic       wfull, awfull, rempty, arempty;
   logic [7:0] rdata;
   int         tests = 0, fails = 0;

   async_fifo_core #(.DSIZE(8), .ASIZE(4)) dut (
      .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .wfull(wfull),
      .awfull(awfull), .rinc(rinc), .rdata(rdata), .rempty(rempty), .arempty(arempty)
   );

   always #5 clk = ~clk;

   task automatic step(input logic w, input logic [7:0] d, input logic r);
      @(negedge clk);
      winc = w; wdata = d; rinc = r;
      @(posedge clk);
      #1;
      winc = 1'b0; rinc = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #12;
      tests++; if (rempty !== 1'b1) begin fails++; $display("FAIL reset_rempty got %b exp 1", rempty); end
      tests++; if (arempty !== 1'b1) begin fails++; $display("FAIL reset_arempty got %b exp 1", arempty); end
      tests++; if (wfull !== 1'b0) begin fails++; $display("FAIL reset_wfull got %b exp 0", wfull); end
      tests++; if (awfull !== 1'b0) begin fails++; $display("FAIL reset_awfull got %b exp 0", awfull); end
      @(negedge clk); rst_n = 1'b1;
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      tests++; if ({rempty, arempty, wfull, awfull} !== 4'b1100) begin fails++; $display("FAIL release_flags got %b exp 1100", {rempty, arempty, wfull, awfull}); end
   endtask

   task automatic test_single;
      step(1'b1, 8'hA5, 1'b0);
      tests++; if (rempty !== 1'b0) begin fails++; $display("FAIL single_rempty got %b exp 0", rempty); end
      tests++; if (arempty !== 1'b1) begin fails++; $display("FAIL single_arempty got %b exp 1", arempty); end
      tests++; if (rdata !== 8'hA5) begin fails++; $display("FAIL single_rdata got %h exp a5", rdata); end
      step(1'b0, 8'h00, 1'b1);
      tests++; if (rempty !== 1'b1) begin fails++; $display("FAIL single_pop_rempty got %b exp 1", rempty); end
   endtask

   task automatic test_fill;
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 8'(i), 1'b0);
         if (i == 13) begin
            tests++; if (awfull !== 1'b0) begin fails++; $display("FAIL fill14_awfull got %b exp 0", awfull); end
         end
         if (i == 14) begin
            tests++; if ({awfull, wfull} !== 2'b10) begin fails++; $display("FAIL fill15_flags got %b exp 10", {awfull, wfull}); end
         end
      end
      tests++; if ({awfull, wfull, arempty} !== 3'b110) begin fails++; $display("FAIL fill16_flags got %b exp 110", {awfull, wfull, arempty}); end
      step(1'b1, 8'hFF, 1'b0);
      tests++; if (wfull !== 1'b1 || rdata !== 8'h00) begin fails++; $display("FAIL fill_drop got wfull=%b rdata=%h exp 1 00", wfull, rdata); end
      for (int i = 0; i < 16; i++) begin
         tests++; if (rdata !== 8'(i)) begin fails++; $display("FAIL fill_read%0d got %h exp %h", i, rdata, 8'(i)); end
         step(1'b0, 8'h00, 1'b1);
      end
      tests++; if (rempty !== 1'b1) begin fails++; $display("FAIL fill_drained got %b exp 1", rempty); end
   endtask

   task automatic test_boundary;
      step(1'b0, 8'h00, 1'b1);
      tests++; if (rempty !== 1'b1) begin fails++; $display("FAIL empty_read_rempty got %b exp 1", rempty); end
      step(1'b1, 8'h3C, 1'b0);
      tests++; if ({rempty, arempty, rdata} !== {2'b01, 8'h3C}) begin fails++; $display("FAIL empty_read_ptr got rempty=%b arempty=%b rdata=%h exp 0 1 3c", rempty, arempty, rdata); end
      step(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
      step(1'b1, 8'hEE, 1'b1);
      tests++; if ({wfull, awfull} !== 2'b01) begin fails++; $display("FAIL full_wr_rd_flags got %b exp 01", {wfull, awfull}); end
      for (int i = 1; i < 16; i++) begin
         tests++; if (rdata !== 8'(8'h40 + i)) begin fails++; $display("FAIL full_wr_rd_read%0d got %h exp %h", i, rdata, 8'(8'h40 + i)); end
         step(1'b0, 8'h00, 1'b1);
      end
      tests++; if (rempty !== 1'b1) begin fails++; $display("FAIL full_wr_rd_count got rempty=%b exp 1", rempty); end
   endtask

   task automatic test_wrap;
      for (int i = 0; i < 3; i++) step(1'b1, 8'(i), 1'b0);
      for (int k = 0; k < 100; k++) begin
         tests++; if (rdata !== 8'(k)) begin fails++; $display("FAIL wrap_data%0d got %h exp %h", k, rdata, 8'(k)); end
         step(1'b1, 8'(k + 3), 1'b1);
         tests++; if ({rempty, arempty, awfull, wfull} !== 4'b0000) begin fails++; $display("FAIL wrap_flags%0d got %b exp 0000", k, {rempty, arempty, awfull, wfull}); end
      end
      for (int k = 100; k < 103; k++) begin
         tests++; if (rdata !== 8'(k)) begin fails++; $display("FAIL wrap_drain%0d got %h exp %h", k, rdata, 8'(k)); end
         step(1'b0, 8'h00, 1'b1);
      end
      tests++; if (rempty !== 1'b1) begin fails++; $display("FAIL wrap_count got rempty=%b exp 1", rempty); end
   endtask

   task automatic test_async_reset;
      for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h90 + i), 1'b0);
      tests++; if (arempty !== 1'b0) begin fails++; $display("FAIL pre_reset_arempty got %b exp 0", arempty); end
      #2 rst_n = 1'b0;
      #1;
      tests++; if ({rempty, arempty, wfull, awfull} !== 4'b1100) begin fails++; $display("FAIL async_reset_flags got %b exp 1100", {rempty, arempty, wfull, awfull}); end
      @(negedge clk); rst_n = 1'b1;
      step(1'b1, 8'h77, 1'b0);
      tests++; if ({rempty, rdata} !== {1'b0, 8'h77}) begin fails++; $display("FAIL post_reset_data got rempty=%b rdata=%h exp 0 77", rempty, rdata); end
      step(1'b0, 8'h00, 1'b1);
      tests++; if (rempty !== 1'b1) begin fails++; $display("FAIL post_reset_pop got %b exp 1", rempty); end
   endtask

   initial begin
      test_reset;
      test_single;
      test_fill;
      test_boundary;
      test_wrap;
      test_async_reset;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
